iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, datapath width; power of two, 8..64.
REQ-002 SHALL provide parameter: MULDIV_EN, 1, 1 = multiply/divide/HI/LO ops implemented; 0 = those opcodes treated as unknown.
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port: start  input  1  request; accepted only in a cycle where ready=1.
REQ-006 SHALL provide port: op  input  6  operation code, sampled at accept.
REQ-007 SHALL provide port: a  input  WIDTH  operand A / shift amount source, sampled at accept.
REQ-008 SHALL provide port: b  input  WIDTH  operand B, sampled at accept.
REQ-009 SHALL provide port: ready  output  1  block can accept start this cycle.
REQ-010 SHALL provide port: done  output  1  one-cycle pulse; result/hi/lo/div_by_zero valid.
REQ-011 SHALL provide port: result  output  WIDTH  registered result, held until next done.
REQ-012 SHALL provide ports: hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-013 SHALL provide port: div_by_zero  output  1  set with done when a DIV/DIVU had b=0.

Function
REQ-014 SHALL implement single-cycle ops with these codes: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 (signed), SLTU 101011, SLL 000000 / SLLV 000100, SRL 000010 / SRLV 000110, SRA 000011 / SRAV 000111, LUI 110000, ANDI 110100, ORI 110101, XORI 110110; all arithmetic modulo 2^WIDTH, no overflow flag.
REQ-015 SHALL use shift amount a[log2(WIDTH)-1:0] and shift b; SRA/SRAV replicate b[WIDTH-1].
REQ-016 SHALL zero-extend b[WIDTH/2-1:0] for ANDI/ORI/XORI, and for LUI produce {b[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-017 SHALL implement multi-cycle ops: MULT 011000, MULTU 011001 ({hi,lo} = 2*WIDTH-bit product); DIV 011010, DIVU 011011 (lo = quotient, hi = remainder); result = lo after these ops.
REQ-018 SHALL implement HI/LO moves: MFHI 010000 (result=hi), MFLO 010010 (result=lo), MTHI 010001 (hi<=a), MTLO 010011 (lo<=a); single-cycle; result=a for MTHI/MTLO.
REQ-019 SHALL use FSM states IDLE, MUL, DIV, DONE; ready=1 in IDLE and DONE, 0 in MUL and DIV.
REQ-020 SHALL sequence: accept in cycle 0 -> single-cycle op: DONE in cycle 1; MULT/MULTU: MUL for WIDTH cycles (shift-add, one bit/cycle) then DONE in cycle WIDTH+1; DIV/DIVU: DIV for WIDTH cycles (restoring, one bit/cycle) then DONE in cycle WIDTH+1.
REQ-021 SHALL assert done only in DONE; DONE -> IDLE if no accept, or directly to the next op's state on accept (back-to-back, no bubble).
REQ-022 SHALL perform signed MULT/DIV on magnitudes with sign fix-up in the final iteration; quotient truncates toward zero, remainder takes dividend's sign.
REQ-023 SHALL, for DIV/DIVU with b=0, skip iteration: DONE in cycle 1, lo=all ones, hi=a, div_by_zero=1.
REQ-024 SHALL, for DIV with a=most-negative and b=-1, produce lo=a, hi=0, div_by_zero=0, full WIDTH+1 latency.
REQ-025 SHALL ignore start when ready=0; operands/op changes after accept have no effect.
REQ-026 SHALL handle unknown op (including muldiv/HI/LO codes when MULDIV_EN=0): result=0, hi/lo unchanged, done in cycle 1.
REQ-027 SHALL hold hi/lo unchanged except on completion of MULT*/DIV*/MTHI/MTLO; div_by_zero cleared on next done.

Reset
REQ-028 SHALL, while rst_n=0, force immediately: state=IDLE, ready=1, done=0, result=0, hi=0, lo=0, div_by_zero=0, iteration counter=0.
REQ-029 SHALL abort any in-flight operation on reset with no done pulse; first accept allowed in the first clock edge with rst_n=1.

Verification
REQ-030 SHALL cover: ADD a=7FFFFFFF b=00000001 -> result 80000000, done in cycle 1; SUB 0-1 -> FFFFFFFF.
REQ-031 SHALL cover: SRA a=4 b=80000000 -> F8000000; SLT a=FFFFFFFF b=1 -> 1; SLTU same -> 0; LUI b=00001234 -> 12340000.
REQ-032 SHALL cover: MULT a=FFFFFFFE b=3 -> hi FFFFFFFF, lo FFFFFFFA, done in cycle 33; ready=0 cycles 1-32; start pulsed in cycle 5 ignored.
REQ-033 SHALL cover: DIV a=FFFFFFF9 (-7) b=2 -> lo FFFFFFFD, hi FFFFFFFF; DIVU a=7 b=0 -> done cycle 1, lo FFFFFFFF, hi 00000007, div_by_zero=1; DIV 80000000/FFFFFFFF -> lo 80000000, hi 0.
REQ-034 SHALL cover: MTHI a=AAAA5555 then MFHI back-to-back in DONE cycle -> result AAAA5555, done in consecutive cycles.
REQ-035 SHALL cover: rst_n low in cycle 10 of MULTU -> all outputs 0, ready=1, no done; WIDTH=16 instance MULTU FFFF*FFFF -> hi FFFE, lo 0001, done in cycle 17.

Source files
------------

// File: rtl/iter_alu.sv
// Iterative ALU with MIPS-style opcodes: single-cycle logic/arith/shift ops plus
// shift-add multiply and restoring divide (one bit per cycle) writing HI/LO.
`timescale 1ns/1ps
module iter_alu #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int HALF = WIDTH / 2;
  localparam int SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] OP_SLL  = 6'o00, OP_SRL  = 6'o02, OP_SRA  = 6'o03;
  localparam logic [5:0] OP_SLLV = 6'o04, OP_SRLV = 6'o06, OP_SRAV = 6'o07;
  localparam logic [5:0] OP_MFHI = 6'o20, OP_MTHI = 6'o21, OP_MFLO = 6'o22, OP_MTLO = 6'o23;
  localparam logic [5:0] OP_MULT = 6'o30, OP_MULTU = 6'o31, OP_DIV = 6'o32, OP_DIVU = 6'o33;
  localparam logic [5:0] OP_ADD  = 6'o40, OP_ADDU = 6'o41, OP_SUB = 6'o42, OP_SUBU = 6'o43;
  localparam logic [5:0] OP_AND  = 6'o44, OP_OR   = 6'o45, OP_XOR = 6'o46, OP_NOR  = 6'o47;
  localparam logic [5:0] OP_SLT  = 6'o52, OP_SLTU = 6'o53;
  localparam logic [5:0] OP_LUI  = 6'o60, OP_ANDI = 6'o64, OP_ORI = 6'o65, OP_XORI = 6'o66;

  logic [1:0]       r_state;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_dbz;
  logic [WIDTH-1:0] r_acc, r_lo_q, r_opnd;
  logic             r_neg_q, r_neg_r;

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res, w_hi_nxt, w_lo_nxt;
  logic             w_dbz, w_go_mul, w_go_div, w_signed, w_a_neg, w_b_neg;

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign ready       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

  assign w_accept = start && ready;
  assign w_shamt  = a[SHW-1:0];
  assign w_a_neg  = w_signed && a[WIDTH-1];
  assign w_b_neg  = w_signed && b[WIDTH-1];

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_res    = '0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    w_dbz    = 1'b0;
    w_go_mul = 1'b0;
    w_go_div = 1'b0;
    w_signed = 1'b0;
    case (op)
      OP_ADD, OP_ADDU:   w_res = a + b;
      OP_SUB, OP_SUBU:   w_res = a - b;
      OP_AND:            w_res = a & b;
      OP_OR:             w_res = a | b;
      OP_XOR:            w_res = a ^ b;
      OP_NOR:            w_res = ~(a | b);
      OP_SLT:            w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:           w_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL, OP_SLLV:   w_res = b << w_shamt;
      OP_SRL, OP_SRLV:   w_res = b >> w_shamt;
      OP_SRA, OP_SRAV:   w_res = $signed(b) >>> w_shamt;
      OP_LUI:            w_res = {b[HALF-1:0], {HALF{1'b0}}};
      OP_ANDI:           w_res = a & {{HALF{1'b0}}, b[HALF-1:0]};
      OP_ORI:            w_res = a | {{HALF{1'b0}}, b[HALF-1:0]};
      OP_XORI:           w_res = a ^ {{HALF{1'b0}}, b[HALF-1:0]};
      OP_MULT, OP_MULTU: if (MULDIV_EN) begin
        w_go_mul = 1'b1;
        w_signed = (op == OP_MULT);
      end
      OP_DIV, OP_DIVU:   if (MULDIV_EN) begin
        w_signed = (op == OP_DIV);
        if (b == '0) begin
          // Divide by zero completes at once instead of iterating.
          w_res    = '1;
          w_lo_nxt = '1;
          w_hi_nxt = a;
          w_dbz    = 1'b1;
        end else begin
          w_go_div = 1'b1;
        end
      end
      OP_MFHI:           if (MULDIV_EN) w_res = r_hi;
      OP_MFLO:           if (MULDIV_EN) w_res = r_lo;
      OP_MTHI:           if (MULDIV_EN) begin w_res = a; w_hi_nxt = a; end
      OP_MTLO:           if (MULDIV_EN) begin w_res = a; w_lo_nxt = a; end
      default:           ;
    endcase
  end

  // Multiply step: r_acc:r_lo_q is the partial product, multiplier shifts out of r_lo_q.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  assign w_sum      = {1'b0, r_acc} + (r_lo_q[0] ? {1'b0, r_opnd} : '0);
  assign w_prod     = {w_sum, r_lo_q[WIDTH-1:1]};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Divide step: r_acc is the remainder, dividend bits shift out of r_lo_q as quotient bits enter.
  logic [WIDTH:0]   w_shift, w_trial;
  logic [WIDTH-1:0] w_rem_nxt, w_quo_nxt, w_rem_fix, w_quo_fix;
  assign w_shift   = {r_acc, r_lo_q[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_opnd};
  assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_lo_q[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // NOTE: non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: datapath scratch registers are reset too, keeping simulation free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
      r_acc    <= '0;
      r_lo_q   <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc  <= w_prod[2*WIDTH-1:WIDTH];
          r_lo_q <= w_prod[WIDTH-1:0];
          r_cnt  <= r_cnt + SHW'(1);
          if (r_cnt == CNT_LAST) begin
            r_hi     <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo     <= w_prod_fix[WIDTH-1:0];
            r_result <= w_prod_fix[WIDTH-1:0];
            r_dbz    <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DIV: begin
          r_acc  <= w_rem_nxt;
          r_lo_q <= w_quo_nxt;
          r_cnt  <= r_cnt + SHW'(1);
          if (r_cnt == CNT_LAST) begin
            r_hi     <= w_rem_fix;
            r_lo     <= w_quo_fix;
            r_result <= w_quo_fix;
            r_dbz    <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          if (!w_accept) begin
            r_state <= S_IDLE;
          end else if (w_go_mul) begin
            r_acc   <= '0;
            r_opnd  <= f_mag(a, w_a_neg);
            r_lo_q  <= f_mag(b, w_b_neg);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_cnt   <= '0;
            r_state <= S_MUL;
          end else if (w_go_div) begin
            r_acc   <= '0;
            r_lo_q  <= f_mag(a, w_a_neg);
            r_opnd  <= f_mag(b, w_b_neg);
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else begin
            r_result <= w_res;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_dbz    <= w_dbz;
            r_state  <= S_DONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: stimulus pushes model expectations, a negedge
// monitor pops them on every done and checks values and completion cycle.
`timescale 1ns/1ps
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  op;
  logic [31:0] a, b;
  logic        ready, done, dbz;
  logic [31:0] result, hi, lo;

  logic        s_start;
  logic [5:0]  s_op;
  logic [15:0] s_a, s_b;
  logic        s_ready, s_done, s_dbz;
  logic [15:0] s_result, s_hi, s_lo;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .hi(hi), .lo(lo), .div_by_zero(dbz));

  iter_alu #(.WIDTH(16), .MULDIV_EN(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .ready(s_ready), .done(s_done), .result(s_result), .hi(s_hi), .lo(s_lo), .div_by_zero(s_dbz));

  typedef struct {
    logic [31:0] res, hi, lo;
    logic        dbz;
    int          due;
    logic [5:0]  op;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  logic [5:0] op_tbl [0:27] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
    6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h30, 6'h34, 6'h35, 6'h36,
    6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the instruction definitions, using native wide arithmetic.
  task automatic model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output logic d, output int lat);
    logic [4:0]  sh;
    longint      sx, sy, sp;
    logic [63:0] up;
    sh  = x[4:0];
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    res = '0;
    d   = 1'b0;
    lat = 1;
    case (o)
      6'h20, 6'h21: res = x + y;
      6'h22, 6'h23: res = x - y;
      6'h24: res = x & y;
      6'h25: res = x | y;
      6'h26: res = x ^ y;
      6'h27: res = ~(x | y);
      6'h2A: res = (sx < sy) ? 32'd1 : 32'd0;
      6'h2B: res = (x < y) ? 32'd1 : 32'd0;
      6'h00, 6'h04: res = y << sh;
      6'h02, 6'h06: res = y >> sh;
      6'h03, 6'h07: res = 32'(sy >>> sh);
      6'h30: res = {y[15:0], 16'h0000};
      6'h34: res = x & {16'h0000, y[15:0]};
      6'h35: res = x | {16'h0000, y[15:0]};
      6'h36: res = x ^ {16'h0000, y[15:0]};
      6'h18: begin sp = sx * sy; {m_hi, m_lo} = sp; res = m_lo; lat = 33; end
      6'h19: begin up = {32'h0, x} * {32'h0, y}; {m_hi, m_lo} = up; res = m_lo; lat = 33; end
      6'h1A, 6'h1B: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x; d = 1'b1; res = '1;
        end else begin
          if (o == 6'h1A) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
          else begin m_lo = x / y; m_hi = x % y; end
          res = m_lo;
          lat = 33;
        end
      end
      6'h10: res = m_hi;
      6'h12: res = m_lo;
      6'h11: begin m_hi = x; res = x; end
      6'h13: begin m_lo = x; res = x; end
      default: res = '0;
    endcase
  endtask

  // Assumes the caller is at a negedge; waits (bounded) for ready, then presents the request.
  task automatic drive(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    int          n;
    exp_t        e;
    logic [31:0] r;
    logic        d;
    int          lat;
    n = 0;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) begin
      check("ready_timeout", {63'd0, ready}, 64'd1);
      return;
    end
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y, r, d, lat);
    e.res = r; e.hi = m_hi; e.lo = m_lo; e.dbz = d; e.due = cyc + lat; e.op = o;
    q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b0;
    drive(o, x, y);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("done_during_reset", {63'd0, done}, 64'd0);
    end else if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("op%02h_result", e.op), {32'd0, result}, {32'd0, e.res});
        check($sformatf("op%02h_hi", e.op), {32'd0, hi}, {32'd0, e.hi});
        check($sformatf("op%02h_lo", e.op), {32'd0, lo}, {32'd0, e.lo});
        check($sformatf("op%02h_dbz", e.op), {63'd0, dbz}, {63'd0, e.dbz});
        check($sformatf("op%02h_done_cycle", e.op), 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    int          c0, n, r;
    logic [5:0]  o;
    logic [31:0] x, y;

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_dbz", {63'd0, dbz}, 64'd0);

    // First accept on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'h20, 32'h7FFFFFFF, 32'h00000001);
    issue(6'h22, 32'h0, 32'h1);
    issue(6'h03, 32'h4, 32'h80000000);
    issue(6'h2A, 32'hFFFFFFFF, 32'h1);
    issue(6'h2B, 32'hFFFFFFFF, 32'h1);
    issue(6'h30, 32'h0, 32'h00001234);

    // MULT busy window: ready low, a start in cycle 5 and operand changes are ignored.
    issue(6'h18, 32'hFFFFFFFE, 32'h3);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      start = (k == 5);
      op = 6'h20; a = 32'h1; b = 32'h1;
      check($sformatf("mult_busy_ready_c%0d", k), {63'd0, ready}, 64'd0);
    end

    issue(6'h1A, 32'hFFFFFFF9, 32'h2);
    issue(6'h1B, 32'h7, 32'h0);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    issue(6'h11, 32'hAAAA5555, 32'h0);
    issue(6'h10, 32'h0, 32'h0);
    issue(6'h3F, 32'h12345678, 32'h9ABCDEF0);

    // 16-bit instance: unsigned FFFF*FFFF.
    @(negedge clk);
    start = 1'b0;
    s_start = 1'b1; s_op = 6'h19; s_a = 16'hFFFF; s_b = 16'hFFFF;
    c0 = cyc;
    n = 0;
    do begin @(negedge clk); s_start = 1'b0; n++; end while (!s_done && n < 40);
    check("w16_done_cycle", 64'(cyc - c0), 64'd17);
    check("w16_hi", {48'd0, s_hi}, 64'h0000_0000_0000_FFFE);
    check("w16_lo", {48'd0, s_lo}, 64'h0000_0000_0000_0001);
    check("w16_result", {48'd0, s_result}, 64'h0000_0000_0000_0001);

    // Randomized traffic with biased corner operands.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 34);
      o = (r < 28) ? op_tbl[r] : 6'($urandom_range(0, 63));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 9));
        3: y = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      issue(o, x, y);
    end

    // Reset in cycle 10 of a MULTU aborts it silently.
    issue(6'h19, $urandom, $urandom);
    c0 = cyc;
    while (cyc < c0 + 10) begin @(negedge clk); start = 1'b0; end
    rst_n = 1'b0;
    #1;
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_dbz", {63'd0, dbz}, 64'd0);
    q.delete();
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(6'h12, 32'h0, 32'h0);
    issue(6'h21, 32'h00000005, 32'hFFFFFFFF);
    issue(6'h1B, 32'd100, 32'd7);

    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) check("drain_pending", 64'(q.size()), 64'd0);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
